// File: rtl/nn_pkg.sv
// ----------------------------------------------------------------------------
// nn_pkg -- state encoding and datapath constants shared by the PU controller.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package nn_pkg;

  localparam int LANES  = 8;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Number of LANES-wide chunks needed to cover a vector of n_lanes elements.
  function automatic int lanes_to_chunks(input int n_lanes);
    return (n_lanes + LANES - 1) / LANES;
  endfunction

endpackage

`default_nettype wire

// File: rtl/addr_gen.sv
// ----------------------------------------------------------------------------
// addr_gen -- neuron/chunk counters with registered x/w/b memory addresses.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module addr_gen
  import nn_pkg::*;
#(
  parameter int CHUNKS = 4,
  parameter int AW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_step,
  input  logic          i_next,
  output logic [AW-1:0] o_x_addr,
  output logic [AW-1:0] o_w_addr,
  output logic [AW-1:0] o_b_addr
);

  localparam logic [AW-1:0] C_CHUNKS = AW'(CHUNKS);

  logic [AW-1:0] r_chunk;
  logic [AW-1:0] r_neuron;
  logic [AW-1:0] r_w_addr;
  logic [AW-1:0] w_chunk_d;
  logic [AW-1:0] w_neuron_d;

  always_comb begin
    w_chunk_d  = r_chunk;
    w_neuron_d = r_neuron;
    if (i_clear) begin
      w_chunk_d  = '0;
      w_neuron_d = '0;
    end else if (i_next) begin
      w_chunk_d  = '0;
      w_neuron_d = r_neuron + AW'(1);
    end else if (i_step) begin
      w_chunk_d  = r_chunk + AW'(1);
    end
  end

  // Weight address is computed from the next counter values so it lines up with x/b.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chunk  <= '0;
      r_neuron <= '0;
      r_w_addr <= '0;
    end else begin
      r_chunk  <= w_chunk_d;
      r_neuron <= w_neuron_d;
      r_w_addr <= w_neuron_d * C_CHUNKS + w_chunk_d;
    end
  end

  assign o_x_addr = r_chunk;
  assign o_w_addr = r_w_addr;
  assign o_b_addr = r_neuron;

endmodule

`default_nettype wire

// File: rtl/pu_controller.sv
// ----------------------------------------------------------------------------
// pu_controller -- sequences chunked weight/input fetches through a PU and
// hands each neuron result to a ready/valid consumer. Optional ReLU on the
// captured result when PU_CTRL_RELU_EN is defined. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pu_controller
  import nn_pkg::*;
#(
  parameter int CHUNKS  = 4,
  parameter int NEURONS = 8,
  parameter int AW      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [AW-1:0]     o_x_addr,
  output logic [AW-1:0]     o_w_addr,
  output logic [AW-1:0]     o_b_addr,
  output logic              o_pu_isfirst,
  input  logic [DATA_W-1:0] i_pu_out,
  output logic [DATA_W-1:0] o_res_data,
  output logic [AW-1:0]     o_res_idx,
  output logic              o_res_valid,
  input  logic              i_res_ready
);

  localparam logic [AW-1:0] C_LAST_CHUNK  = AW'(CHUNKS - 1);
  localparam logic [AW-1:0] C_LAST_NEURON = AW'(NEURONS - 1);
  localparam bit            C_MULTI_CHUNK = (CHUNKS > 1);

  state_t            r_state;
  logic              r_last;
  logic              w_clear;
  logic              w_step;
  logic              w_next;
  logic              w_accept;
  logic              w_chunk_last;
  logic              w_neuron_last;
  logic [DATA_W-1:0] w_res;

  assign w_chunk_last  = (o_x_addr == C_LAST_CHUNK);
  assign w_neuron_last = (o_b_addr == C_LAST_NEURON);
  assign w_accept      = (r_state == OUT) && i_res_ready;
  assign w_clear       = (r_state == IDLE) && i_start;
  // The handshake cycle already presents chunk 0 of the next neuron, so it advances to chunk 1.
  assign w_step        = ((r_state == FETCH) && !w_chunk_last) ||
                         (w_accept && !r_last && C_MULTI_CHUNK);
  // Chunk 0 of the next neuron is preloaded while the result waits in OUT.
  assign w_next        = (r_state == DRAIN) && !w_neuron_last;

`ifdef PU_CTRL_RELU_EN
  assign w_res = i_pu_out[DATA_W-1] ? '0 : i_pu_out;
`else
  assign w_res = i_pu_out;
`endif

  addr_gen #(
    .CHUNKS (CHUNKS),
    .AW     (AW)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_clear),
    .i_step   (w_step),
    .i_next   (w_next),
    .o_x_addr (o_x_addr),
    .o_w_addr (o_w_addr),
    .o_b_addr (o_b_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last       <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_res_valid  <= 1'b0;
      o_pu_isfirst <= 1'b0;
      o_res_data   <= '0;
      o_res_idx    <= '0;
    end else begin
      o_done       <= 1'b0;
      o_pu_isfirst <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= FETCH;
            o_busy  <= 1'b1;
          end
        end
        FETCH: begin
          o_pu_isfirst <= (o_x_addr == '0);
          if (w_chunk_last) r_state <= DRAIN;
        end
        DRAIN: begin
          o_res_data  <= w_res;
          o_res_idx   <= o_b_addr;
          o_res_valid <= 1'b1;
          r_last      <= w_neuron_last;
          r_state     <= OUT;
        end
        OUT: begin
          if (i_res_ready) begin
            o_res_valid <= 1'b0;
            if (r_last) begin
              r_state <= DONE;
              o_done  <= 1'b1;
              o_busy  <= 1'b0;
            end else begin
              o_pu_isfirst <= 1'b1;
              r_state      <= C_MULTI_CHUNK ? FETCH : DRAIN;
            end
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/pu_controller.md
PU_CONTROLLER -- requirements
Module: pu_controller

Interface
REQ-001 Parameter CHUNKS, default 4: number of 8-lane chunks per neuron, 1..255.
REQ-002 Parameter NEURONS, default 8: neurons per layer, 1..255.
REQ-003 Parameter AW, default 8: width of every address output.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle layer start request.
REQ-007 busy  out  1  high from the cycle after an accepted start until done.
REQ-008 done  out  1  one-cycle pulse after the last neuron result is accepted.
REQ-009 x_addr  out  AW  input-vector memory address (chunk index).
REQ-010 w_addr  out  AW  weight memory address (neuron*CHUNKS + chunk).
REQ-011 b_addr  out  AW  bias memory address (neuron index).
REQ-012 pu_isfirst  out  1  drives the PU isfirst input.
REQ-013 pu_out  in  8  PU result, signed two's complement.
REQ-014 res_data  out  8  captured neuron result.
REQ-015 res_idx  out  AW  neuron index of res_data.
REQ-016 res_valid  out  1  res_data/res_idx valid.
REQ-017 res_ready  in  1  consumer accepts the result when res_valid and res_ready are both high.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, DRAIN, OUT and DONE.
REQ-019 IDLE: start=1 -> FETCH with neuron=0, chunk=0; start is ignored in every other state.
REQ-020 FETCH: x_addr=chunk, w_addr=neuron*CHUNKS+chunk and b_addr=neuron are issued every cycle; chunk increments each cycle; after chunk=CHUNKS-1 -> DRAIN.
REQ-021 The memories SHALL have 1-cycle synchronous read latency, so data for chunk c reaches the PU one cycle after c is issued.
REQ-022 pu_isfirst SHALL be 1 exactly in the data cycle of chunk 0 and 0 in all other cycles (registered copy of "chunk==0 issued").
REQ-023 DRAIN (data cycle of the last chunk): on its closing edge res_data <= f(pu_out), res_idx <= neuron, then -> OUT.
REQ-024 OUT: res_valid=1 with res_data/res_idx held stable until res_ready=1.
REQ-025 OUT with res_ready=1: if neuron=NEURONS-1 -> DONE; else neuron increments, chunk=0, -> FETCH.
REQ-026 DONE: done=1 for one cycle, busy=0 -> IDLE.
REQ-027 Latency: start to the first res_valid = CHUNKS+2 cycles; each further neuron takes CHUNKS+1 cycles after the previous handshake.
REQ-028 CHUNKS=1: FETCH lasts one cycle, and pu_isfirst=1 in DRAIN.
REQ-029 Address arithmetic SHALL be unsigned and wrap modulo 2^AW; the integrator must ensure NEURONS*CHUNKS <= 2^AW.
REQ-030 Outside FETCH and DRAIN, address outputs SHALL hold their last values and pu_isfirst=0.

Reset
REQ-031 rst_n=0 SHALL immediately force: state IDLE; busy, done, res_valid and pu_isfirst = 0; res_data, res_idx, x_addr, w_addr, b_addr, neuron and chunk = 0.
REQ-032 Reset mid-operation SHALL abandon the layer with no done pulse; the next start begins again at neuron 0.

Configuration
REQ-033 Macro PU_CTRL_RELU_EN defined: f(x) = 0 when x[7]=1, else x (ReLU on the captured result).
REQ-034 Macro PU_CTRL_RELU_EN undefined: f(x) = x (raw signed value).

Structure
REQ-035 Shared package nn_pkg SHALL hold the state enum (IDLE/FETCH/DRAIN/OUT/DONE), LANES=8 and DATA_W=8.
REQ-036 A sub-module addr_gen (neuron/chunk counters plus w_addr multiply-add) is natural; the FSM stays in pu_controller.

Verification
REQ-037 CHUNKS=4, NEURONS=2, res_ready tied 1, start at cycle 0:
- busy at cycles 1..11; x_addr 0,1,2,3 then 0,1,2,3;
- w_addr 0..3 then 4..7;
- res_valid at cycles 6 and 11 with res_idx 0 and 1; done at cycle 12.
REQ-038 pu_isfirst alignment: pu_isfirst=1 only in cycles where the memory delivers chunk-0 data (cycles 2 and 7 in REQ-037).
REQ-039 Backpressure: hold res_ready=0 for 5 cycles in OUT -> res_valid stays 1, res_data/res_idx stable, no address change; resume on res_ready=1.
REQ-040 ReLU: pu_out=8'hF0 in DRAIN -> res_data=8'h00 with PU_CTRL_RELU_EN defined, 8'hF0 without; pu_out=8'h35 -> 8'h35 in both builds.
REQ-041 Reset and start handling:
- rst_n pulsed low during FETCH of neuron 1 -> all outputs zero at once, no done pulse;
- a following start yields res_idx 0 first;
- start pulsed while busy -> ignored.
REQ-042 CHUNKS=1, NEURONS=1: start -> pu_isfirst=1 and res capture one cycle after FETCH, res_valid at cycle 3, done one cycle after the handshake.
